// File: rtl/game_pkg.sv
// Shared game-sequencer types and HID constants, also consumed by render logic.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_IN_GAME   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_RESPAWN   = 3'd4,
    ST_GAME_END  = 3'd5
  } game_state_t;

  localparam logic [7:0] KEY_P = 8'h13;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Keyboard/frame inputs and screen/status outputs of the game sequencer.
interface game_state_ctrl_if #(
  parameter int KEY_SLOTS = 3,
  parameter int LIVES_W   = 2
);
  logic                   frame_tick;
  logic                   player_die;
  logic [8*KEY_SLOTS-1:0] keycode;
  logic                   start_screen;
  logic                   countdown_screen;
  logic                   game_screen;
  logic                   paused;
  logic                   respawning;
  logic                   game_over;
  logic                   new_game;
  logic [LIVES_W-1:0]     lives_left;
  logic [3:0]             countdown_val;

  modport master (
    output frame_tick, player_die, keycode,
    input  start_screen, countdown_screen, game_screen, paused, respawning,
           game_over, new_game, lives_left, countdown_val
  );

  modport slave (
    input  frame_tick, player_die, keycode,
    output start_screen, countdown_screen, game_screen, paused, respawning,
           game_over, new_game, lives_left, countdown_val
  );
endinterface

// File: rtl/game_state_ctrl_key_edge_detect.sv
// Press-edge detection over all HID slots: generic any-key press and pause-key press.
module key_edge_detect
  import game_pkg::*;
#(
  parameter int         KEY_SLOTS = 3,
  parameter logic [7:0] PAUSE_KEY = KEY_P
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [KEY_SLOTS-1:0][7:0] keycode,
  output logic                      key_press,
  output logic                      pause_press
);

  logic [KEY_SLOTS-1:0] slot_hit;
  logic                 any_key;
  logic                 pause_now;
  logic                 armed;
  logic                 pause_prev;

  for (genvar i = 0; i < KEY_SLOTS; i++) begin : g_slot
    assign slot_hit[i] = (keycode[i] == PAUSE_KEY);
  end

  assign any_key   = |keycode;
  assign pause_now = |slot_hit;

  // armed only after an all-empty cycle, so a key held through any transition is not a press
  always_ff @(posedge Clk) begin
    if (Reset) begin
      armed      <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      armed      <= ~any_key;
      pause_prev <= pause_now;
    end
  end

  assign key_press   = armed & any_key;
  assign pause_press = pause_now & ~pause_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: start/countdown/play/pause/respawn/over with lives and frame-timed counters.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int         KEY_SLOTS      = 3,
  parameter int         LIVES          = 3,
  parameter int         LIVES_W        = 2,
  parameter int         COUNT_STEPS    = 3,
  parameter int         STEP_FRAMES    = 60,
  parameter int         RESPAWN_FRAMES = 120,
  parameter logic [7:0] PAUSE_KEY      = KEY_P
) (
  input  logic             Clk,
  input  logic             Reset,
  game_state_ctrl_if.slave bus
);

  localparam int FC_W = $clog2(max2(STEP_FRAMES, RESPAWN_FRAMES)) + 1;
  localparam logic [FC_W-1:0]    STEP_LAST    = FC_W'(STEP_FRAMES - 1);
  localparam logic [FC_W-1:0]    RESP_LAST    = FC_W'(RESPAWN_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);

  game_state_t        state, state_n;
  logic [FC_W-1:0]    fc, fc_n;
  logic [LIVES_W-1:0] lives, lives_n;
  logic [3:0]         cval, cval_n;
  logic               new_game_q, new_game_n;
  logic               key_press, pause_press;

  key_edge_detect #(
    .KEY_SLOTS (KEY_SLOTS),
    .PAUSE_KEY (PAUSE_KEY)
  ) u_keys (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode     (bus.keycode),
    .key_press   (key_press),
    .pause_press (pause_press)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_START;
      fc         <= '0;
      lives      <= LIVES_INIT;
      cval       <= '0;
      new_game_q <= 1'b0;
    end else begin
      state      <= state_n;
      fc         <= fc_n;
      lives      <= lives_n;
      cval       <= cval_n;
      new_game_q <= new_game_n;
    end
  end

  always_comb begin
    state_n    = state;
    fc_n       = fc;
    lives_n    = lives;
    cval_n     = cval;
    new_game_n = 1'b0;
    case (state)
      ST_START: begin
        if (key_press) begin
          state_n    = ST_COUNTDOWN;
          new_game_n = 1'b1;
          lives_n    = LIVES_INIT;
          cval_n     = 4'(COUNT_STEPS);
          fc_n       = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (bus.frame_tick) begin
          if (fc == STEP_LAST) begin
            fc_n = '0;
            if (cval == 4'd1) begin
              state_n = ST_IN_GAME;
              cval_n  = 4'd0;
            end else begin
              cval_n = cval - 4'd1;
            end
          end else begin
            fc_n = fc + FC_W'(1);
          end
        end
      end
      ST_IN_GAME: begin
        // death wins over a simultaneous pause edge
        if (bus.player_die) begin
          if (lives == LIVES_W'(1)) begin
            state_n = ST_GAME_END;
            lives_n = '0;
          end else begin
            state_n = ST_RESPAWN;
            lives_n = lives - LIVES_W'(1);
            fc_n    = '0;
          end
        end else if (pause_press) begin
          state_n = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_press) state_n = ST_IN_GAME;
      end
      ST_RESPAWN: begin
        if (bus.frame_tick) begin
          if (fc == RESP_LAST) begin
            state_n = ST_IN_GAME;
            fc_n    = '0;
          end else begin
            fc_n = fc + FC_W'(1);
          end
        end
      end
      ST_GAME_END: begin
        if (key_press) state_n = ST_START;
      end
      default: state_n = ST_START;
    endcase
  end

  assign bus.start_screen     = (state == ST_START);
  assign bus.countdown_screen = (state == ST_COUNTDOWN);
  assign bus.game_screen      = (state == ST_IN_GAME);
  assign bus.paused           = (state == ST_PAUSED);
  assign bus.respawning       = (state == ST_RESPAWN);
  assign bus.game_over        = (state == ST_GAME_END);
  assign bus.new_game         = new_game_q;
  assign bus.lives_left       = lives;
  assign bus.countdown_val    = cval;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench: directed scenario plus random traffic against a tick-budget model.
module tb_game_state_ctrl;

  localparam int KS = 3;
  localparam int LV = 3;
  localparam int LW = 2;
  localparam int CS = 3;
  localparam int SF = 2;
  localparam int RF = 3;

  // mode numbering follows the order of the one-hot outputs, start_screen = bit 0
  localparam int M_START = 0, M_CD = 1, M_GAME = 2, M_PAUSE = 3, M_RESP = 4, M_END = 5;

  typedef struct packed {
    int mode;
    int lives;
    int ticks;   // frame ticks left in the whole countdown
    int resp;    // frame ticks left in respawn grace
    bit ng;
    bit armed;
    bit pprev;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   failed   = 0;
  bit   m_valid  = 1'b0;
  mstate_t m = '0;

  game_state_ctrl_if #(.KEY_SLOTS(KS), .LIVES_W(LW)) bus ();

  game_state_ctrl #(
    .KEY_SLOTS(KS), .LIVES(LV), .LIVES_W(LW), .COUNT_STEPS(CS),
    .STEP_FRAMES(SF), .RESPAWN_FRAMES(RF), .PAUSE_KEY(8'h13)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic mstate_t mstep(mstate_t s, logic [23:0] kc, bit ft, bit pd, bit r);
    mstate_t n = s;
    bit any_k = (kc != 24'h0);
    bit pnow  = (kc[7:0] == 8'h13) || (kc[15:8] == 8'h13) || (kc[23:16] == 8'h13);
    bit kp    = s.armed && any_k;
    bit pp    = pnow && !s.pprev;
    if (r) begin
      n = '0;
      n.mode  = M_START;
      n.lives = LV;
      return n;
    end
    n.ng = 1'b0;
    case (s.mode)
      M_START: if (kp) begin
        n.mode = M_CD; n.ng = 1'b1; n.lives = LV; n.ticks = CS * SF;
      end
      M_CD: if (ft) begin
        n.ticks = s.ticks - 1;
        if (n.ticks == 0) n.mode = M_GAME;
      end
      M_GAME: begin
        if (pd) begin
          if (s.lives == 1) begin n.mode = M_END; n.lives = 0; end
          else begin n.mode = M_RESP; n.lives = s.lives - 1; n.resp = RF; end
        end else if (pp) n.mode = M_PAUSE;
      end
      M_PAUSE: if (pp) n.mode = M_GAME;
      M_RESP: if (ft) begin
        n.resp = s.resp - 1;
        if (n.resp == 0) n.mode = M_GAME;
      end
      M_END: if (kp) n.mode = M_START;
      default: n.mode = M_START;
    endcase
    n.armed = !any_k;
    n.pprev = pnow;
    return n;
  endfunction

  always @(posedge clk) begin
    m       <= mstep(m, bus.keycode, bus.frame_tick, bus.player_die, rst);
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [5:0]    exp_oh, act_oh;
      logic [3:0]    exp_cv;
      logic [LW-1:0] exp_lv;
      exp_oh = 6'(1 << m.mode);
      exp_cv = 4'((m.ticks + SF - 1) / SF);
      exp_lv = LW'(m.lives);
      act_oh = {bus.game_over, bus.respawning, bus.paused, bus.game_screen,
                bus.countdown_screen, bus.start_screen};
      compared++;
      if (act_oh !== exp_oh || bus.new_game !== m.ng || bus.lives_left !== exp_lv ||
          bus.countdown_val !== exp_cv) begin
        failed++;
        $display("FAIL model_cmp t=%0t: got state=%b ng=%b lives=%0d cv=%0d, want state=%b ng=%b lives=%0d cv=%0d",
                 $time, act_oh, bus.new_game, bus.lives_left, bus.countdown_val,
                 exp_oh, m.ng, exp_lv, exp_cv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [23:0] kc, input bit ft, input bit pd);
    bus.keycode    = kc;
    bus.frame_tick = ft;
    bus.player_die = pd;
    @(posedge clk);
    #1;
  endtask

  logic [23:0] kc_r;

  initial begin
    bus.keycode = '0; bus.frame_tick = 1'b0; bus.player_die = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    rst = 1'b0;
    chk("reset_start", bus.start_screen, 1);
    chk("reset_lives", bus.lives_left, 3);
    chk("reset_cv", bus.countdown_val, 0);
    chk("reset_ng", bus.new_game, 0);

    step(0, 0, 0);
    step(24'h000004, 0, 0);
    chk("launch_ng", bus.new_game, 1);
    chk("launch_cd", bus.countdown_screen, 1);
    chk("launch_cv", bus.countdown_val, 3);
    chk("launch_lives", bus.lives_left, 3);
    step(0, 1, 0);
    chk("ng_pulse_once", bus.new_game, 0);
    chk("cd_tick1", bus.countdown_val, 3);
    step(0, 1, 0);
    chk("cd_tick2", bus.countdown_val, 2);
    step(0, 1, 0); step(0, 1, 0);
    chk("cd_tick4", bus.countdown_val, 1);
    step(0, 1, 0);
    chk("cd_tick5", bus.countdown_screen, 1);
    step(0, 1, 0);
    chk("cd_done_game", bus.game_screen, 1);
    chk("cd_done_cv", bus.countdown_val, 0);

    step(0, 0, 1);
    chk("die1_resp", bus.respawning, 1);
    chk("die1_lives", bus.lives_left, 2);
    step(0, 1, 1); step(0, 1, 1);
    chk("resp_invuln", bus.respawning, 1);
    chk("resp_invuln_lives", bus.lives_left, 2);
    step(0, 1, 0);
    chk("resp_done", bus.game_screen, 1);

    for (int i = 0; i < 5; i++) step(24'h001300, 0, 0);
    chk("pause_held", bus.paused, 1);
    step(0, 0, 1);
    chk("pause_die_ign", bus.paused, 1);
    chk("pause_die_lives", bus.lives_left, 2);
    step(24'h001300, 0, 0);
    chk("unpause", bus.game_screen, 1);

    step(0, 0, 0);
    step(24'h001300, 0, 1);
    chk("die_beats_pause", bus.respawning, 1);
    chk("die2_lives", bus.lives_left, 1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("resp2_done", bus.game_screen, 1);

    step(24'h000004, 0, 1);
    chk("die3_end", bus.game_over, 1);
    chk("die3_lives", bus.lives_left, 0);
    step(24'h000004, 0, 0); step(24'h000004, 0, 0); step(24'h000004, 0, 0);
    chk("held_key_ign", bus.game_over, 1);
    step(0, 0, 0);
    step(24'h000004, 0, 0);
    chk("end_to_start", bus.start_screen, 1);
    chk("start_lives0", bus.lives_left, 0);

    step(0, 0, 0);
    step(24'h040000, 0, 0);
    chk("relaunch_lives", bus.lives_left, 3);
    step(0, 1, 0); step(0, 1, 0);
    chk("relaunch_cv", bus.countdown_val, 2);
    rst = 1'b1;
    step(0, 1, 0);
    rst = 1'b0;
    chk("midcd_rst_start", bus.start_screen, 1);
    chk("midcd_rst_cv", bus.countdown_val, 0);
    chk("midcd_rst_lives", bus.lives_left, 3);

    kc_r = '0;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: kc_r = 24'h000000;
        4:          kc_r = 24'h000004;
        5:          kc_r = 24'h001300;
        6:          kc_r = 24'h130000;
        7:          kc_r = 24'h131600;
        8:          kc_r = kc_r;
        default:    kc_r = 24'($urandom);
      endcase
      rst = ($urandom_range(0, 399) == 0);
      step(kc_r, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    rst = 1'b0;
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
